// File: rtl/aes_sched_pkg.sv
// ----------------------------------------------------------------------------
// aes_sched_pkg
// Shared definitions for the AES request scheduler:
//   - sched_state_e : scheduler FSM states (IDLE/LOAD/WAIT/RESP)
//   - AES_W         : width of AES key, plaintext and ciphertext words
//   - AES_LATENCY   : nominal ld-to-done latency of the shared AES core
// ----------------------------------------------------------------------------
package aes_sched_pkg;

    localparam int AES_W       = 128;
    localparam int AES_LATENCY = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } sched_state_e;

endpackage

// File: rtl/aes_req_sched_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority pick. The winner is the first set bit
// of req_i at or after ptr_i, wrapping modulo N.
//
// Ports:
//   req_i   [N-1:0]  request vector
//   ptr_i   [PW-1:0] round-robin pointer (highest-priority position)
//   grant_o [N-1:0]  one-hot grant, zero when no request
//   any_o            at least one request is present
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          any_o
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] grant_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   grant_rot;

    // Rotate the requests so that position ptr_i lands at bit 0: shifting
    // a doubled copy right performs the wrap without a modulo.
    assign req_dbl   = {req_i, req_i} >> ptr_i;
    assign req_rot   = req_dbl[N-1:0];

    // Isolate the lowest set bit of the rotated vector.
    assign grant_rot = req_rot & (~req_rot + ONE);

    // Rotate back: the upper half of the doubled, left-shifted copy holds
    // the grant in original requester positions.
    assign grant_dbl = {grant_rot, grant_rot} << ptr_i;
    assign grant_o   = grant_dbl[2*N-1:N];

    assign any_o     = |req_i;

endmodule

// File: rtl/aes_req_sched.sv
// ----------------------------------------------------------------------------
// aes_req_sched
// Round-robin scheduler sharing one AES encryption core between N_REQ
// requesters. One operation is in flight at a time: grant, single-cycle load
// strobe, wait for done (guarded by a watchdog), then hand the ciphertext
// back on the owner's response handshake.
//
// Ports:
//   clk                      clock
//   rst                      synchronous reset, active low
//   req_valid  [N_REQ]       per-requester request valid
//   req_ready  [N_REQ]       per-requester accept (combinational, one-hot)
//   req_key    [N_REQ*128]   flattened keys, requester i at [128*i +: 128]
//   req_text   [N_REQ*128]   flattened plaintexts, same packing
//   resp_valid [N_REQ]       per-requester response valid (one-hot)
//   resp_ready [N_REQ]       per-requester response accept
//   resp_data  [128]         ciphertext, qualified by resp_valid
//   resp_err                 timeout flag, qualified by resp_valid
//   aes_ld                   load strobe to the core
//   aes_key    [128]         key to the core
//   aes_text   [128]         plaintext to the core
//   aes_text_out [128]       core result
//   aes_done                 core completion
//   busy                     high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module aes_req_sched
    import aes_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*AES_W-1:0] req_key,
    input  logic [N_REQ*AES_W-1:0] req_text,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [AES_W-1:0]       resp_data,
    output logic                   resp_err,
    output logic                   aes_ld,
    output logic [AES_W-1:0]       aes_key,
    output logic [AES_W-1:0]       aes_text,
    input  logic [AES_W-1:0]       aes_text_out,
    input  logic                   aes_done,
    output logic                   busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sched_state_e       state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;
    logic [PTR_W-1:0]   owner_q;
    logic [N_REQ-1:0]   owner_oh_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [AES_W-1:0]   key_q;
    logic [AES_W-1:0]   text_q;
    logic [AES_W-1:0]   resp_data_q;
    logic               resp_err_q;
    logic [N_REQ-1:0]   resp_valid_q;
    logic               ld_q;

    logic [N_REQ-1:0]   grant;
    logic               any_req;
    logic [PTR_W-1:0]   win_idx;
    logic [AES_W-1:0]   win_key;
    logic [AES_W-1:0]   win_text;
    logic               owner_ready;
    logic               first_wait;
    logic               timeout_hit;

    rr_pick #(
        .N  (N_REQ),
        .PW (PTR_W)
    ) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .any_o   (any_req)
    );

    // One-hot grant to index and AND-OR selection of the winner's key and
    // plaintext, built as accumulation chains over the requesters.
    logic [PTR_W-1:0] idx_acc  [N_REQ+1];
    logic [AES_W-1:0] key_acc  [N_REQ+1];
    logic [AES_W-1:0] text_acc [N_REQ+1];

    assign idx_acc[0]  = '0;
    assign key_acc[0]  = '0;
    assign text_acc[0] = '0;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_sel
            assign idx_acc[gi+1]  = idx_acc[gi]
                                  | (grant[gi] ? PTR_W'(gi) : '0);
            assign key_acc[gi+1]  = key_acc[gi]
                                  | ({AES_W{grant[gi]}} & req_key[AES_W*gi +: AES_W]);
            assign text_acc[gi+1] = text_acc[gi]
                                  | ({AES_W{grant[gi]}} & req_text[AES_W*gi +: AES_W]);
        end
    endgenerate

    assign win_idx  = idx_acc[N_REQ];
    assign win_key  = key_acc[N_REQ];
    assign win_text = text_acc[N_REQ];

    // Next pointer: the requester after the current owner, wrapping.
    assign rr_ptr_d = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

    // Watchdog: the counter is cleared in LOAD, so it reads 0 in the first
    // WAIT cycle; that is the cycle in which a lingering done is ignored.
    assign cnt_d       = cnt_q + CNT_W'(1);
    assign first_wait  = (cnt_q == '0);
    assign timeout_hit = (cnt_d == CNT_W'(TIMEOUT));

    // resp_valid_q is the owner's one-hot while in RESP, so masking with it
    // ignores ready from every other requester.
    assign owner_ready = |(resp_ready & resp_valid_q);

    // The accept is combinational in IDLE; it is held off during reset so a
    // requester never sees a handshake that the FSM does not take.
    assign req_ready  = (state_q == ST_IDLE && rst) ? grant : '0;

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign aes_ld     = ld_q;
    assign aes_key    = key_q;
    assign aes_text   = text_q;
    assign busy       = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            owner_oh_q   <= '0;
            cnt_q        <= '0;
            key_q        <= '0;
            text_q       <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= '0;
            ld_q         <= 1'b0;
        end else begin
            ld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        key_q      <= win_key;
                        text_q     <= win_text;
                        owner_q    <= win_idx;
                        owner_oh_q <= grant;
                        ld_q       <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_d;
                    // Done is tested first so it wins over a coincident timeout.
                    if (aes_done && !first_wait) begin
                        resp_data_q  <= aes_text_out;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= owner_oh_q;
                        state_q      <= ST_RESP;
                    end else if (timeout_hit) begin
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= owner_oh_q;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (owner_ready) begin
                        resp_valid_q <= '0;
                        rr_ptr_q     <= rr_ptr_d;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_sched.sv
// ----------------------------------------------------------------------------
// tb_aes_req_sched
// Directed bench for aes_req_sched. A small behavioural core answers each
// load strobe with a one-cycle done pulse AES_LATENCY cycles later, carrying
// the known ciphertext for the two standard test vectors.
// ----------------------------------------------------------------------------
module tb_aes_req_sched;
    import aes_sched_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 64;

    localparam logic [127:0] K1    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1    = 128'h69c4e0d86a7b0430d8cdb780ce98c55a;
    localparam logic [127:0] K2    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C2    = 128'h3ad77bb40d7a3660a89ecaf3733aef97;
    localparam logic [127:0] STALE = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    localparam logic [127:0] JUNK  = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*128-1:0] req_key = '0;
    logic [N*128-1:0] req_text = '0;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready = '0;
    logic [127:0]   resp_data;
    logic           resp_err;
    logic           aes_ld;
    logic [127:0]   aes_key;
    logic [127:0]   aes_text;
    logic [127:0]   aes_text_out;
    logic           aes_done;
    logic           busy;

    int checks = 0;
    int passes = 0;

    // Core model state and overrides
    logic         core_done_r = 1'b0;
    logic [127:0] core_out_r  = '0;
    int           core_cnt    = 0;
    bit           core_active = 1'b0;
    logic         force_lo    = 1'b0;
    logic         force_hi    = 1'b0;

    assign aes_done     = force_hi | (core_done_r & ~force_lo);
    assign aes_text_out = force_hi ? STALE : core_out_r;

    always #5 clk = ~clk;

    aes_req_sched #(
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_key      (req_key),
        .req_text     (req_text),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .aes_ld       (aes_ld),
        .aes_key      (aes_key),
        .aes_text     (aes_text),
        .aes_text_out (aes_text_out),
        .aes_done     (aes_done),
        .busy         (busy)
    );

    function automatic logic [127:0] cipher_model(input logic [127:0] k, input logic [127:0] p);
        if (k == K1 && p == P1) return C1;
        if (k == K2 && p == P2) return C2;
        return k ^ p;
    endfunction

    // Behavioural core: ld seen in cycle L gives done high during cycle L+12.
    always @(negedge clk) begin
        if (!rst) begin
            core_active = 1'b0;
            core_cnt    = 0;
            core_done_r = 1'b0;
        end else begin
            core_done_r = 1'b0;
            if (aes_ld) begin
                core_active = 1'b1;
                core_cnt    = 0;
                core_out_r  = cipher_model(aes_key, aes_text);
            end else if (core_active) begin
                core_cnt++;
                if (core_cnt == AES_LATENCY) begin
                    core_done_r = 1'b1;
                    core_active = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [127:0] k, input logic [127:0] p);
        case (i)
            0: begin req_key[127:0]   = k; req_text[127:0]   = p; end
            1: begin req_key[255:128] = k; req_text[255:128] = p; end
            2: begin req_key[383:256] = k; req_text[383:256] = p; end
            3: begin req_key[511:384] = k; req_text[511:384] = p; end
            default: ;
        endcase
    endtask

    // Advance until a response is valid (bounded); n = cycles waited,
    // lds = load strobes observed along the way.
    task automatic wait_resp(output int n, output int lds);
        n   = 0;
        lds = 0;
        while (resp_valid == '0 && n < 200) begin
            if (aes_ld) lds++;
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({req_ready, resp_valid, aes_ld, resp_err, busy} !== 11'b0) begin
            $display("FAIL reset_ctrl: got %b expected 0", {req_ready, resp_valid, aes_ld, resp_err, busy});
        end else passes++;
        checks++;
        if ({resp_data, aes_key, aes_text} !== '0) begin
            $display("FAIL reset_data: got data=%h key=%h text=%h expected 0", resp_data, aes_key, aes_text);
        end else passes++;
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, req_ready} !== 5'b0) begin
            $display("FAIL reset_idle_quiet: got busy=%b ready=%b expected 0", busy, req_ready);
        end else passes++;
        $display("reset: done");
    endtask

    task automatic test_single();
        int n, lds;
        set_slot(0, K1, P1);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL single_grant: got %b expected 0001", req_ready);
        else passes++;
        tick();
        req_valid = '0;
        set_slot(0, JUNK, JUNK);
        checks++;
        if ({aes_ld, aes_key, aes_text} !== {1'b1, K1, P1})
            $display("FAIL single_load: got ld=%b key=%h text=%h expected ld=1 key=%h text=%h", aes_ld, aes_key, aes_text, K1, P1);
        else passes++;
        wait_resp(n, lds);
        checks++;
        if (n + 1 != 14) $display("FAIL single_latency: got %0d expected 14", n + 1);
        else passes++;
        checks++;
        if (resp_valid !== 4'b0001) $display("FAIL single_resp_valid: got %b expected 0001", resp_valid);
        else passes++;
        checks++;
        if ({resp_data, resp_err} !== {C1, 1'b0})
            $display("FAIL single_resp_data: got %h err=%b expected %h err=0", resp_data, resp_err, C1);
        else passes++;
        checks++;
        if (lds != 1) $display("FAIL single_ld_pulses: got %0d expected 1", lds);
        else passes++;
        checks++;
        if (aes_key !== K1) $display("FAIL single_key_hold: got %h expected %h", aes_key, K1);
        else passes++;
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        checks++;
        if ({resp_valid, busy} !== 5'b0) $display("FAIL single_release: got valid=%b busy=%b expected 0", resp_valid, busy);
        else passes++;
        $display("single: req0 latency=%0d data=%h", n + 1, C1);
    endtask

    task automatic test_fairness();
        int n, lds;
        logic [N-1:0] exp_oh;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_slot(i, K2, P2);
        req_valid  = 4'hF;
        resp_ready = 4'hF;
        #1;
        for (int i = 0; i < N; i++) begin
            exp_oh = 4'b0001 << i;
            checks++;
            if (req_ready !== exp_oh) $display("FAIL fair_grant%0d: got %b expected %b", i, req_ready, exp_oh);
            else passes++;
            tick();
            wait_resp(n, lds);
            checks++;
            if (resp_valid !== exp_oh) $display("FAIL fair_resp_valid%0d: got %b expected %b", i, resp_valid, exp_oh);
            else passes++;
            checks++;
            if (resp_data !== C2) $display("FAIL fair_resp_data%0d: got %h expected %h", i, resp_data, C2);
            else passes++;
            if (i == N - 1) req_valid = 4'b1010;
            tick();
            $display("fairness: grant %0d done", i);
        end
        checks++;
        if (req_ready !== 4'b0010) $display("FAIL fair_rereq_first: got %b expected 0010", req_ready);
        else passes++;
        tick();
        req_valid = 4'b1000;
        wait_resp(n, lds);
        checks++;
        if (resp_valid !== 4'b0010) $display("FAIL fair_rereq_resp1: got %b expected 0010", resp_valid);
        else passes++;
        tick();
        checks++;
        if (req_ready !== 4'b1000) $display("FAIL fair_rereq_second: got %b expected 1000", req_ready);
        else passes++;
        tick();
        req_valid = '0;
        wait_resp(n, lds);
        checks++;
        if ({resp_valid, resp_data} !== {4'b1000, C2})
            $display("FAIL fair_rereq_resp3: got %b %h expected 1000 %h", resp_valid, resp_data, C2);
        else passes++;
        tick();
        resp_ready = '0;
        $display("fairness: re-request order 1,3 done");
    endtask

    task automatic test_backpressure();
        int n, lds;
        set_slot(2, K1, P1);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) $display("FAIL bp_grant: got %b expected 0100", req_ready);
        else passes++;
        tick();
        req_valid  = 4'b1011;
        resp_ready = 4'b1011;
        wait_resp(n, lds);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({resp_valid, resp_data, resp_err, aes_ld, req_ready, busy} !== {4'b0100, C1, 1'b0, 1'b0, 4'b0000, 1'b1})
                $display("FAIL bp_hold%0d: got valid=%b data=%h err=%b ld=%b ready=%b busy=%b expected 0100 %h 0 0 0000 1",
                         c, resp_valid, resp_data, resp_err, aes_ld, req_ready, busy, C1);
            else passes++;
            tick();
        end
        resp_ready = 4'b1111;
        tick();
        checks++;
        if ({resp_valid, req_ready} !== {4'b0000, 4'b1000})
            $display("FAIL bp_release: got valid=%b ready=%b expected 0000 1000", resp_valid, req_ready);
        else passes++;
        tick();
        req_valid = '0;
        wait_resp(n, lds);
        checks++;
        if ({resp_valid, resp_data} !== {4'b1000, C2})
            $display("FAIL bp_next_resp: got %b %h expected 1000 %h", resp_valid, resp_data, C2);
        else passes++;
        tick();
        resp_ready = '0;
        $display("backpressure: held 10 cycles, release ok");
    endtask

    task automatic test_timeout();
        int n, lds;
        force_lo = 1'b1;
        set_slot(0, K1, P1);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL tmo_grant: got %b expected 0001", req_ready);
        else passes++;
        tick();
        req_valid = '0;
        wait_resp(n, lds);
        checks++;
        if (n + 1 != TMO + 2) $display("FAIL tmo_latency: got %0d expected %0d", n + 1, TMO + 2);
        else passes++;
        checks++;
        if ({resp_valid, resp_err, resp_data} !== {4'b0001, 1'b1, 128'h0})
            $display("FAIL tmo_resp: got valid=%b err=%b data=%h expected 0001 1 0", resp_valid, resp_err, resp_data);
        else passes++;
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        force_lo   = 1'b0;
        set_slot(1, K1, P1);
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = '0;
        wait_resp(n, lds);
        checks++;
        if (n + 1 != 14) $display("FAIL tmo_recover_latency: got %0d expected 14", n + 1);
        else passes++;
        checks++;
        if ({resp_valid, resp_err, resp_data} !== {4'b0010, 1'b0, C1})
            $display("FAIL tmo_recover_resp: got valid=%b err=%b data=%h expected 0010 0 %h", resp_valid, resp_err, resp_data, C1);
        else passes++;
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        $display("timeout: error after %0d cycles, recovery ok", TMO + 2);
    endtask

    task automatic test_stale_done();
        int n, lds;
        set_slot(2, K2, P2);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) $display("FAIL stale_grant: got %b expected 0100", req_ready);
        else passes++;
        tick();
        req_valid = '0;
        force_hi  = 1'b1;
        checks++;
        if (aes_ld !== 1'b1) $display("FAIL stale_ld: got %b expected 1", aes_ld);
        else passes++;
        tick();
        tick();
        force_hi = 1'b0;
        checks++;
        if (resp_valid !== 4'b0000) $display("FAIL stale_not_captured: got %b expected 0000", resp_valid);
        else passes++;
        wait_resp(n, lds);
        checks++;
        if (n + 3 != 14) $display("FAIL stale_latency: got %0d expected 14", n + 3);
        else passes++;
        checks++;
        if ({resp_valid, resp_err, resp_data} !== {4'b0100, 1'b0, C2})
            $display("FAIL stale_resp: got valid=%b err=%b data=%h expected 0100 0 %h", resp_valid, resp_err, resp_data, C2);
        else passes++;
        resp_ready = 4'b0100;
        tick();
        resp_ready = '0;
        $display("stale_done: ignored, data=%h", C2);
    endtask

    task automatic test_reset_wait();
        int n, lds;
        int stray;
        set_slot(2, K1, P1);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) $display("FAIL rstw_grant: got %b expected 0100", req_ready);
        else passes++;
        tick();
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if ({req_ready, resp_valid, aes_ld, resp_err, busy} !== 11'b0)
            $display("FAIL rstw_ctrl: got %b expected 0", {req_ready, resp_valid, aes_ld, resp_err, busy});
        else passes++;
        checks++;
        if ({resp_data, aes_key, aes_text} !== '0)
            $display("FAIL rstw_data: got data=%h key=%h text=%h expected 0", resp_data, aes_key, aes_text);
        else passes++;
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid != '0) stray++;
            tick();
        end
        checks++;
        if (stray != 0) $display("FAIL rstw_no_resp: got %0d response cycles expected 0", stray);
        else passes++;
        set_slot(0, K2, P2);
        set_slot(1, K2, P2);
        req_valid = 4'b0011;
        #1;
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL rstw_ptr: got %b expected 0001", req_ready);
        else passes++;
        tick();
        req_valid = '0;
        wait_resp(n, lds);
        checks++;
        if ({resp_valid, resp_data} !== {4'b0001, C2})
            $display("FAIL rstw_next_resp: got %b %h expected 0001 %h", resp_valid, resp_data, C2);
        else passes++;
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        $display("reset_in_wait: abandoned, next grant to 0");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_stale_done();
        test_reset_wait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1, "global timeout");
    end

endmodule
